// File: rtl/booth_mac_seq.sv
// booth_mac_seq
// Sequential dual-product multiply-accumulate: acc <= acc + a*b + c*d.
// Two radix-2 Booth lanes run in lock-step, one step per clock, followed by
// a single accumulate cycle. Optional saturation and a sticky overflow flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any operation)
//   in_valid   a/b/c/d/clr_acc are valid
//   in_ready   unit is idle and can accept an operation this cycle
//   a, b       multiplicand / multiplier of product 1 (signed)
//   c, d       multiplicand / multiplier of product 2 (signed)
//   clr_acc    with an accepted op: accumulate onto 0 instead of acc;
//              alone while idle: clear acc and ovf at the next edge
//   out_valid  one-cycle pulse, acc holds a new result
//   acc        accumulator (signed)
//   busy       an operation is in progress
//   ovf        sticky overflow flag
module booth_mac_seq #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 12,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  input  logic [WIDTH-1:0]     d,
  input  logic                 clr_acc,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 busy,
  output logic                 ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  // Two guard bits so the sum of two products and the base cannot wrap.
  localparam int FW = ACC_WIDTH + 2;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        count_reg, count_next;
  logic                 clr_pend_reg, clr_pend_next;
  logic [ACC_WIDTH-1:0] acc_reg, acc_next;
  logic                 ovf_reg, ovf_next;
  logic                 out_valid_reg, out_valid_next;

  // Per-lane Booth state: lane 0 = a*b, lane 1 = c*d.
  logic [WIDTH-1:0]     mcand_reg [2];
  logic [WIDTH-1:0]     mcand_next [2];
  logic [WIDTH:0]       u_reg [2];
  logic [WIDTH:0]       u_next [2];
  logic [WIDTH-1:0]     q_reg [2];
  logic [WIDTH-1:0]     q_next [2];
  logic [1:0]           qm1_reg, qm1_next;

  // Per-lane combinational step results and sign-extended products.
  logic [WIDTH-1:0]     in_mcand [2];
  logic [WIDTH-1:0]     in_mplier [2];
  logic [WIDTH:0]       step_u [2];
  logic [WIDTH-1:0]     step_q [2];
  logic [1:0]           step_qm1;
  logic [FW-1:0]        prod_ext [2];

  assign in_mcand[0]  = a;
  assign in_mcand[1]  = c;
  assign in_mplier[0] = b;
  assign in_mplier[1] = d;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [WIDTH:0]     mc_ext;
      logic [WIDTH:0]     sum;
      logic [2*WIDTH-1:0] prod;

      // U is one bit wider than the operand so -(-2^(W-1)) is representable.
      assign mc_ext = {mcand_reg[gi][WIDTH-1], mcand_reg[gi]};

      always_comb begin
        sum = u_reg[gi];
        case ({q_reg[gi][0], qm1_reg[gi]})
          2'b10:   sum = u_reg[gi] - mc_ext;
          2'b01:   sum = u_reg[gi] + mc_ext;
          default: sum = u_reg[gi];
        endcase
      end

      // Arithmetic right shift of {U, Q, q_m1}.
      assign step_u[gi]   = {sum[WIDTH], sum[WIDTH:1]};
      assign step_q[gi]   = {sum[0], q_reg[gi][WIDTH-1:1]};
      assign step_qm1[gi] = q_reg[gi][0];

      assign prod         = {u_reg[gi][WIDTH-1:0], q_reg[gi]};
      assign prod_ext[gi] = {{(FW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    end
  endgenerate

  // Accumulate-cycle arithmetic.
  logic [FW-1:0]        base;
  logic [FW-1:0]        full;
  logic                 acc_of;
  logic [ACC_WIDTH-1:0] acc_result;

  assign base   = clr_pend_reg ? '0 : {{2{acc_reg[ACC_WIDTH-1]}}, acc_reg};
  assign full   = prod_ext[0] + prod_ext[1] + base;
  // Fits in ACC_WIDTH signed iff the top three bits all agree.
  assign acc_of = !((&full[FW-1:ACC_WIDTH-1]) || !(|full[FW-1:ACC_WIDTH-1]));
  assign acc_result = (SATURATE != 0 && acc_of) ? (full[FW-1] ? ACC_MIN : ACC_MAX)
                                                : full[ACC_WIDTH-1:0];

  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    clr_pend_next  = clr_pend_reg;
    acc_next       = acc_reg;
    ovf_next       = ovf_reg;
    out_valid_next = 1'b0;
    qm1_next       = qm1_reg;
    for (int i = 0; i < 2; i++) begin
      mcand_next[i] = mcand_reg[i];
      u_next[i]     = u_reg[i];
      q_next[i]     = q_reg[i];
    end

    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          for (int i = 0; i < 2; i++) begin
            mcand_next[i] = in_mcand[i];
            u_next[i]     = '0;
            q_next[i]     = in_mplier[i];
          end
          qm1_next      = '0;
          count_next    = CW'(WIDTH);
          clr_pend_next = clr_acc;
          state_next    = MUL;
        end else if (clr_acc) begin
          acc_next = '0;
          ovf_next = 1'b0;
        end
      end
      MUL: begin
        for (int i = 0; i < 2; i++) begin
          u_next[i] = step_u[i];
          q_next[i] = step_q[i];
        end
        qm1_next   = step_qm1;
        count_next = count_reg - CW'(1);
        if (count_reg == CW'(1)) begin
          state_next = ACC;
        end
      end
      ACC: begin
        acc_next       = acc_result;
        // A clearing op restarts overflow tracking from this op alone.
        ovf_next       = clr_pend_reg ? acc_of : (ovf_reg | acc_of);
        out_valid_next = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      clr_pend_reg  <= 1'b0;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      qm1_reg       <= '0;
      for (int i = 0; i < 2; i++) begin
        mcand_reg[i] <= '0;
        u_reg[i]     <= '0;
        q_reg[i]     <= '0;
      end
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      clr_pend_reg  <= clr_pend_next;
      acc_reg       <= acc_next;
      ovf_reg       <= ovf_next;
      out_valid_reg <= out_valid_next;
      qm1_reg       <= qm1_next;
      for (int i = 0; i < 2; i++) begin
        mcand_reg[i] <= mcand_next[i];
        u_reg[i]     <= u_next[i];
        q_reg[i]     <= q_next[i];
      end
    end
  end

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign busy      = (state_reg != IDLE);
  assign acc       = acc_reg;
  assign ovf       = ovf_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_booth_mac_seq.sv
// Directed testbench for booth_mac_seq.
// dut0: WIDTH=4, ACC_WIDTH=12, wrap. dut1/dut2: WIDTH=4, ACC_WIDTH=9,
// saturating / wrapping, driven in parallel for the narrow-accumulator case.
module tb_booth_mac_seq;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, clr_acc;
  logic [3:0] a, b, c, d;
  logic in_ready0, out_valid0, busy0, ovf0;
  logic [11:0] acc0;

  logic iv4, clr4;
  logic rdy1, ov1, busy1, ovf1;
  logic [8:0] acc1;
  logic rdy2, ov2, busy2, ovf2;
  logic [8:0] acc2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_mac_seq #(.WIDTH(4), .ACC_WIDTH(12), .SATURATE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .c(c), .d(d), .clr_acc(clr_acc),
    .out_valid(out_valid0), .acc(acc0), .busy(busy0), .ovf(ovf0)
  );

  booth_mac_seq #(.WIDTH(4), .ACC_WIDTH(9), .SATURATE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy1),
    .a(a), .b(b), .c(c), .d(d), .clr_acc(clr4),
    .out_valid(ov1), .acc(acc1), .busy(busy1), .ovf(ovf1)
  );

  booth_mac_seq #(.WIDTH(4), .ACC_WIDTH(9), .SATURATE(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy2),
    .a(a), .b(b), .c(c), .d(d), .clr_acc(clr4),
    .out_valid(ov2), .acc(acc2), .busy(busy2), .ovf(ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One operation on dut0: wait for ready, accept, expect out_valid exactly
  // 5 edges after the accept edge, then check acc and ovf.
  task automatic do_op(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                       input logic [3:0] tc, input logic [3:0] td, input logic tclr,
                       input int exp_acc, input int exp_ovf);
    int w;
    w = 0;
    while (!in_ready0 && w < 20) begin
      tick();
      w++;
    end
    chk({tag, "_ready"}, in_ready0, 1);
    a = ta; b = tb; c = tc; d = td;
    clr_acc = tclr;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    clr_acc = 1'b0;
    chk({tag, "_busy"}, busy0, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk({tag, "_ovalid"}, out_valid0, (k == 5) ? 1 : 0);
    end
    chk({tag, "_acc"}, $signed(acc0), exp_acc);
    chk({tag, "_ovf"}, ovf0, exp_ovf);
    $display("op %s: acc=%0d ovf=%0b", tag, $signed(acc0), ovf0);
  endtask

  initial begin
    int acc_e[2];
    int n_acc;
    int pulses;
    int between_bad;
    int exp_acc;
    int exp_ovf;
    logic will_acc;

    rst = 1'b1; in_valid = 1'b0; clr_acc = 1'b0; iv4 = 1'b0; clr4 = 1'b0;
    a = '0; b = '0; c = '0; d = '0;

    // Reset state
    tick(); tick();
    chk("rst_acc", $signed(acc0), 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_ovalid", out_valid0, 0);
    chk("rst_ready", in_ready0, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", in_ready0, 1);
    $display("reset: acc=%0d busy=%0b in_ready=%0b", $signed(acc0), busy0, in_ready0);

    // 1: 3*-2 + 5*4 = 14
    do_op("s1", 4'sh3, 4'shE, 4'sh5, 4'sh4, 1'b0, 14, 0);
    // 2: most-negative operands, -8*-8 + -8*-8 = 128
    do_op("s2", 4'sh8, 4'sh8, 4'sh8, 4'sh8, 1'b0, 142, 0);

    // 3: in_valid held for two operand sets
    a = 4'sh1; b = 4'sh1; c = 4'sh1; d = 4'sh1;
    in_valid = 1'b1;
    n_acc = 0; pulses = 0; between_bad = 0;
    acc_e[0] = -100; acc_e[1] = -100;
    for (int cyc = 0; cyc < 20; cyc++) begin
      will_acc = in_valid && in_ready0;
      tick();
      if (will_acc) begin
        acc_e[n_acc] = cyc;
        n_acc++;
        a = 4'sh2; b = 4'sh3; c = 4'shF; d = 4'sh4;
        if (n_acc == 2) in_valid = 1'b0;
      end
      if (out_valid0) pulses++;
      if (n_acc >= 1 && cyc - acc_e[0] >= 0 && cyc - acc_e[0] <= 4)
        if (!(busy0 && !in_ready0)) between_bad++;
    end
    in_valid = 1'b0;
    chk("s3_accepts", n_acc, 2);
    chk("s3_spacing", acc_e[1] - acc_e[0], 6);
    chk("s3_between", between_bad, 0);
    chk("s3_pulses", pulses, 2);
    chk("s3_acc", $signed(acc0), 146);
    $display("op s3: spacing=%0d pulses=%0d acc=%0d", acc_e[1] - acc_e[0], pulses, $signed(acc0));

    // Drive dut0 into overflow: +128 per op from 146; wraps on the 15th op.
    for (int k = 1; k <= 15; k++) begin
      exp_acc = 146 + 128 * k;
      exp_ovf = 0;
      if (exp_acc > 2047) begin
        exp_acc = exp_acc - 4096;
        exp_ovf = 1;
      end
      do_op("ovf_run", 4'sh8, 4'sh8, 4'sh8, 4'sh8, 1'b0, exp_acc, exp_ovf);
    end

    // 5: clearing op restarts from 0 and clears ovf
    do_op("s5_clrop", 4'sh1, 4'sh1, 4'sh0, 4'sh0, 1'b1, 1, 0);
    clr_acc = 1'b1;
    tick();
    clr_acc = 1'b0;
    chk("s5_clr_acc", $signed(acc0), 0);
    chk("s5_clr_ovalid", out_valid0, 0);
    chk("s5_clr_busy", busy0, 0);
    tick();
    chk("s5_clr_ovalid2", out_valid0, 0);
    $display("clr alone: acc=%0d out_valid=%0b", $signed(acc0), out_valid0);

    // 6: reset during the 2nd MUL cycle
    do_op("s6_pre", 4'sh1, 4'sh1, 4'sh0, 4'sh0, 1'b0, 1, 0);
    a = 4'sh3; b = 4'sh3; c = 4'sh3; d = 4'sh3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("s6_acc", $signed(acc0), 0);
    chk("s6_busy", busy0, 0);
    chk("s6_ready", in_ready0, 0);
    chk("s6_ovalid", out_valid0, 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid0) pulses++;
    end
    chk("s6_no_ovalid", pulses, 0);
    $display("reset abort: acc=%0d pulses=%0d", $signed(acc0), pulses);

    // 4: ACC_WIDTH=9, two -8 ops; saturate vs wrap
    for (int k = 0; k < 2; k++) begin
      a = 4'sh8; b = 4'sh8; c = 4'sh8; d = 4'sh8;
      iv4 = 1'b1;
      tick();
      iv4 = 1'b0;
      for (int j = 1; j <= 5; j++) begin
        tick();
        chk("s4_ov_sat", ov1, (j == 5) ? 1 : 0);
        chk("s4_ov_wrap", ov2, (j == 5) ? 1 : 0);
      end
      chk("s4_acc_sat", $signed(acc1), (k == 0) ? 128 : 255);
      chk("s4_acc_wrap", $signed(acc2), (k == 0) ? 128 : -256);
      chk("s4_ovf_sat", ovf1, k);
      chk("s4_ovf_wrap", ovf2, k);
      $display("op s4[%0d]: sat acc=%0d ovf=%0b wrap acc=%0d ovf=%0b",
               k, $signed(acc1), ovf1, $signed(acc2), ovf2);
      tick();
    end
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    chk("s4_clr_acc", $signed(acc1), 0);
    chk("s4_clr_ovf", ovf1, 0);
    chk("s4_clr_ovalid", ov1, 0);
    $display("clr alone narrow: acc=%0d ovf=%0b", $signed(acc1), ovf1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
